// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: FETCH/DECODE/EXEC/WB sequencer; R-type/ADDI 4 cycles, BEQ/JMP/NOP 3, HALT after 2; no backpressure.
// `define FETCH_DECODE_RETIRE_CNT_EN to add the 16-bit RetiredCount output.
module fetch_decode_ctrl #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  output logic [PC_WIDTH-1:0] InstrAddr,
  input  logic [15:0]         InstrData,
  input  logic [15:0]         ALUResult,
  input  logic                ALUZero,
  output logic [1:0]          rs,
  output logic [1:0]          rt,
  output logic [1:0]          rd,
  output logic                RegWrite,
  output logic [15:0]         WriteData,
  output logic [1:0]          ALUOp,
  output logic                ALUSrcImm,
  output logic [15:0]         Immediate,
`ifdef FETCH_DECODE_RETIRE_CNT_EN
  output logic [15:0]         RetiredCount,
`endif
  output logic                Halted
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_JMP  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  logic [2:0]          state;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;
  logic [15:0]         writeDataQ;

  logic [3:0]          opcode;
  logic                isRType;
  logic                isAddi;
  logic                isBeq;
  logic                isJmp;
  logic                writesReg;
  logic                retireEvt;
  logic [PC_WIDTH-1:0] pcInc;
  logic [PC_WIDTH-1:0] branchTarget;
  logic [PC_WIDTH-1:0] jumpTarget;

  assign opcode    = ir[15:12];
  assign isRType   = (opcode[3:2] == 2'b00);
  assign isAddi    = (opcode == OP_ADDI);
  assign isBeq     = (opcode == OP_BEQ);
  assign isJmp     = (opcode == OP_JMP);
  assign writesReg = isRType || isAddi;

  // Decoded fields come straight from IR, so they hold until the next FETCH reloads it.
  assign rs        = ir[11:10];
  assign rt        = ir[9:8];
  assign rd        = isAddi ? ir[9:8] : ir[7:6];
  assign Immediate = {{8{ir[7]}}, ir[7:0]};
  assign ALUSrcImm = isAddi;

  always_comb begin
    ALUOp = 2'b00;
    if (isRType) begin
      ALUOp = opcode[1:0];
    end else if (isBeq) begin
      ALUOp = 2'b01;
    end
  end

  // Reset suppresses the write pulse in the same cycle so an aborted WB never lands.
  assign RegWrite  = (state == ST_WB) && !Reset;
  assign Halted    = (state == ST_HALT);
  assign WriteData = writeDataQ;
  assign InstrAddr = pc;

  assign pcInc        = pc + PC_ONE;
  assign branchTarget = pcInc + Immediate[PC_WIDTH-1:0];
  assign jumpTarget   = ir[PC_WIDTH-1:0];
  assign retireEvt    = (state == ST_WB) || ((state == ST_EXEC) && !writesReg);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      ir         <= 16'h0000;
      writeDataQ <= 16'h0000;
    end else begin
      case (state)
        ST_FETCH: begin
          ir    <= InstrData;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          state <= (opcode == OP_HALT) ? ST_HALT : ST_EXEC;
        end
        ST_EXEC: begin
          writeDataQ <= ALUResult;
          if (writesReg) begin
            state <= ST_WB;
          end else begin
            state <= ST_FETCH;
            if (isBeq) begin
              pc <= ALUZero ? branchTarget : pcInc;
            end else if (isJmp) begin
              pc <= jumpTarget;
            end else begin
              pc <= pcInc;
            end
          end
        end
        ST_WB: begin
          pc    <= pcInc;
          state <= ST_FETCH;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_DECODE_RETIRE_CNT_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RetiredCount <= 16'h0000;
    end else if (retireEvt) begin
      RetiredCount <= RetiredCount + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: instruction memory, 4-entry register file and ALU stubs around the DUT,
// with a write-back scoreboard fed by each test and drained by a RegWrite monitor.
module tb_fetch_decode_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  InstrAddr;
  logic [15:0] InstrData;
  logic [15:0] ALUResult;
  logic        ALUZero;
  logic [1:0]  rs, rt, rd, ALUOp;
  logic        RegWrite, ALUSrcImm, Halted;
  logic [15:0] WriteData, Immediate;
`ifdef FETCH_DECODE_RETIRE_CNT_EN
  logic [15:0] RetiredCount;
`endif

  typedef struct packed {
    logic [1:0]  rd;
    logic [15:0] data;
  } wr_t;

  logic [15:0] imem [256];
  logic [15:0] regs [4] = '{default: 16'h0000};
  logic [15:0] opA, opB;
  int          zeroMode = 0;
  wr_t         expQ[$];
  int          passCount = 0;
  int          checkCount = 0;

  fetch_decode_ctrl #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .Clock(Clock), .Reset(Reset), .InstrAddr(InstrAddr), .InstrData(InstrData),
    .ALUResult(ALUResult), .ALUZero(ALUZero), .rs(rs), .rt(rt), .rd(rd),
    .RegWrite(RegWrite), .WriteData(WriteData), .ALUOp(ALUOp), .ALUSrcImm(ALUSrcImm),
    .Immediate(Immediate),
`ifdef FETCH_DECODE_RETIRE_CNT_EN
    .RetiredCount(RetiredCount),
`endif
    .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  assign InstrData = imem[InstrAddr];

  always_comb begin
    opA = regs[rs];
    opB = ALUSrcImm ? Immediate : regs[rt];
    case (ALUOp)
      2'b00:   ALUResult = opA + opB;
      2'b01:   ALUResult = opA - opB;
      2'b10:   ALUResult = opA & opB;
      default: ALUResult = opA | opB;
    endcase
  end

  assign ALUZero = (zeroMode == 1) ? 1'b1 : (zeroMode == 2) ? 1'b0 : (ALUResult == 16'h0000);

  always @(posedge Clock) begin
    if (RegWrite) regs[rd] <= WriteData;
  end

  always @(negedge Clock) begin
    wr_t e;
    if (RegWrite) begin
      checkCount++;
      if (expQ.size() == 0) begin
        $display("FAIL sb_unexpected_write rd=%0d data=%h", rd, WriteData);
      end else begin
        e = expQ.pop_front();
        if (rd !== e.rd || WriteData !== e.data)
          $display("FAIL sb_write got rd=%0d data=%h want rd=%0d data=%h", rd, WriteData, e.rd, e.data);
        else passCount++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
  endtask

  task automatic fillNop();
    for (int i = 0; i < 256; i++) imem[i] = 16'h7000;
  endtask

  task automatic test_reset();
    fillNop();
    doReset();
    checkCount++; if (InstrAddr !== 8'h00) $display("FAIL rst_pc got %h want 00", InstrAddr); else passCount++;
    checkCount++; if (Halted !== 1'b0 || RegWrite !== 1'b0) $display("FAIL rst_flags got H=%b W=%b want 0 0", Halted, RegWrite); else passCount++;
    checkCount++; if ({rs, rt, rd, ALUOp, ALUSrcImm} !== 9'h000) $display("FAIL rst_decode got %h want 000", {rs, rt, rd, ALUOp, ALUSrcImm}); else passCount++;
    checkCount++; if (WriteData !== 16'h0000) $display("FAIL rst_wdata got %h want 0000", WriteData); else passCount++;
`ifdef FETCH_DECODE_RETIRE_CNT_EN
    checkCount++; if (RetiredCount !== 16'h0000) $display("FAIL rst_retired got %0d want 0", RetiredCount); else passCount++;
`endif
  endtask

  task automatic test_addi();
    fillNop();
    imem[0] = 16'h410F;
    doReset();
    expQ.push_back({2'd1, 16'd15});
    checkCount++; if (InstrAddr !== 8'h00) $display("FAIL addi_fetch_pc got %h want 00", InstrAddr); else passCount++;
    tick(1);
    checkCount++; if (rs !== 2'd0 || rt !== 2'd1) $display("FAIL addi_decode got rs=%0d rt=%0d want 0 1", rs, rt); else passCount++;
    tick(1);
    checkCount++; if (ALUSrcImm !== 1'b1 || Immediate !== 16'h000F || RegWrite !== 1'b0)
      $display("FAIL addi_exec got src=%b imm=%h w=%b want 1 000f 0", ALUSrcImm, Immediate, RegWrite); else passCount++;
    tick(1);
    checkCount++; if (RegWrite !== 1'b1 || rd !== 2'd1 || WriteData !== 16'd15)
      $display("FAIL addi_wb got w=%b rd=%0d d=%0d want 1 1 15", RegWrite, rd, WriteData); else passCount++;
    tick(1);
    checkCount++; if (InstrAddr !== 8'h01 || RegWrite !== 1'b0) $display("FAIL addi_next got pc=%h w=%b want 01 0", InstrAddr, RegWrite); else passCount++;
    checkCount++; if (expQ.size() != 0) $display("FAIL addi_sb_left got %0d want 0", expQ.size()); else passCount++;
  endtask

  task automatic test_rtype();
    fillNop();
    imem[0] = 16'h410F;
    imem[1] = 16'h4209;
    imem[2] = 16'h06C0;
    doReset();
    expQ.push_back({2'd1, 16'd15});
    expQ.push_back({2'd2, 16'd9});
    expQ.push_back({2'd3, 16'd24});
    tick(8);
    checkCount++; if (InstrAddr !== 8'h02) $display("FAIL add_pc got %h want 02", InstrAddr); else passCount++;
    tick(2);
    checkCount++; if (ALUOp !== 2'b00 || RegWrite !== 1'b0) $display("FAIL add_exec got op=%b w=%b want 00 0", ALUOp, RegWrite); else passCount++;
    tick(1);
    checkCount++; if (RegWrite !== 1'b1 || rd !== 2'd3 || WriteData !== 16'd24)
      $display("FAIL add_wb got w=%b rd=%0d d=%0d want 1 3 24", RegWrite, rd, WriteData); else passCount++;
    tick(1);
    checkCount++; if (RegWrite !== 1'b0 || InstrAddr !== 8'h03) $display("FAIL add_next got w=%b pc=%h want 0 03", RegWrite, InstrAddr); else passCount++;
    checkCount++; if (regs[3] !== 16'd24) $display("FAIL add_regfile got %0d want 24", regs[3]); else passCount++;
    checkCount++; if (expQ.size() != 0) $display("FAIL add_sb_left got %0d want 0", expQ.size()); else passCount++;
  endtask

  task automatic test_beq();
    fillNop();
    imem[0] = 16'h6005;
    imem[5] = 16'h50FE;
    zeroMode = 1;
    doReset();
    tick(3);
    checkCount++; if (InstrAddr !== 8'h05) $display("FAIL beq_at5 got %h want 05", InstrAddr); else passCount++;
    tick(2);
    checkCount++; if (ALUOp !== 2'b01 || ALUSrcImm !== 1'b0) $display("FAIL beq_exec got op=%b src=%b want 01 0", ALUOp, ALUSrcImm); else passCount++;
    tick(1);
    checkCount++; if (InstrAddr !== 8'h04) $display("FAIL beq_taken got %h want 04", InstrAddr); else passCount++;
    zeroMode = 2;
    doReset();
    tick(6);
    checkCount++; if (InstrAddr !== 8'h06) $display("FAIL beq_not_taken got %h want 06", InstrAddr); else passCount++;
    zeroMode = 0;
  endtask

  task automatic test_jmp_wrap();
    fillNop();
    imem[0]   = 16'h60FF;
    imem[255] = 16'h4105;
    doReset();
    expQ.push_back({2'd1, 16'd5});
    tick(3);
    checkCount++; if (InstrAddr !== 8'hFF) $display("FAIL jmp_target got %h want ff", InstrAddr); else passCount++;
    tick(4);
    checkCount++; if (InstrAddr !== 8'h00) $display("FAIL pc_wrap got %h want 00", InstrAddr); else passCount++;
    checkCount++; if (regs[1] !== 16'd5 || expQ.size() != 0) $display("FAIL wrap_write got r1=%0d left=%0d want 5 0", regs[1], expQ.size()); else passCount++;
  endtask

  task automatic test_halt();
    int bad;
    fillNop();
    imem[3] = 16'hF000;
    doReset();
    tick(9);
    checkCount++; if (InstrAddr !== 8'h03) $display("FAIL halt_pc got %h want 03", InstrAddr); else passCount++;
    tick(1);
    checkCount++; if (Halted !== 1'b0) $display("FAIL halt_early got %b want 0", Halted); else passCount++;
    tick(1);
    checkCount++; if (Halted !== 1'b1) $display("FAIL halt_enter got %b want 1", Halted); else passCount++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (InstrAddr !== 8'h03 || RegWrite !== 1'b0 || Halted !== 1'b1) bad++;
    end
    checkCount++; if (bad != 0) $display("FAIL halt_frozen got %0d bad cycles want 0", bad); else passCount++;
    doReset();
    checkCount++; if (InstrAddr !== 8'h00 || Halted !== 1'b0) $display("FAIL halt_reset got pc=%h h=%b want 00 0", InstrAddr, Halted); else passCount++;
  endtask

  task automatic test_reset_mid_wb();
    logic [15:0] snap;
    fillNop();
    imem[0] = 16'h06C0;
    snap = regs[3];
    doReset();
    tick(3);
    checkCount++; if (RegWrite !== 1'b1) $display("FAIL midwb_in_wb got %b want 1", RegWrite); else passCount++;
    Reset = 1'b1;
    #1;
    checkCount++; if (RegWrite !== 1'b0) $display("FAIL midwb_gated got %b want 0", RegWrite); else passCount++;
    tick(1);
    Reset = 1'b0;
    #1;
    checkCount++; if (RegWrite !== 1'b0 || InstrAddr !== 8'h00 || Halted !== 1'b0)
      $display("FAIL midwb_after got w=%b pc=%h h=%b want 0 00 0", RegWrite, InstrAddr, Halted); else passCount++;
    checkCount++; if (regs[3] !== snap) $display("FAIL midwb_no_write got %h want %h", regs[3], snap); else passCount++;
  endtask

  task automatic test_back_to_back();
    int cycles;
    fillNop();
    imem[0] = 16'h410F;
    imem[1] = 16'h4209;
    imem[2] = 16'h16C0;
    imem[3] = 16'h7000;
    imem[4] = 16'h26C0;
    imem[5] = 16'h3600;
    imem[6] = 16'h46FF;
    imem[7] = 16'hF000;
    doReset();
    expQ.push_back({2'd1, 16'd15});
    expQ.push_back({2'd2, 16'd9});
    expQ.push_back({2'd3, 16'd6});
    expQ.push_back({2'd3, 16'd9});
    expQ.push_back({2'd0, 16'd15});
    expQ.push_back({2'd2, 16'd14});
    cycles = 0;
    while (Halted !== 1'b1 && cycles < 100) begin
      tick(1);
      cycles++;
`ifdef FETCH_DECODE_RETIRE_CNT_EN
      if (cycles == 12) begin
        checkCount++; if (RetiredCount !== 16'd3) $display("FAIL retired_3 got %0d want 3", RetiredCount); else passCount++;
      end
`endif
    end
    checkCount++; if (cycles != 29) $display("FAIL b2b_cycles got %0d want 29", cycles); else passCount++;
    checkCount++; if (expQ.size() != 0) $display("FAIL b2b_sb_left got %0d want 0", expQ.size()); else passCount++;
`ifdef FETCH_DECODE_RETIRE_CNT_EN
    checkCount++; if (RetiredCount !== 16'd7) $display("FAIL retired_7 got %0d want 7", RetiredCount); else passCount++;
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype();
    test_beq();
    test_jmp_wrap();
    test_halt();
    test_reset_mid_wb();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
